// File: rtl/reconfig_multi_topo_b.sv
// Two-operand unit, one shared adder steered by {s1,s0}; 1-cycle result.
// Build option: RECONFIG_SAT_EN makes topology 10 clamp negatives to 0.
module reconfig_multi_topo_b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b,
  input  logic             s0,
  input  logic             s1,
  output logic             out_valid,
  output logic [WIDTH:0]   y
);

  logic [1:0]     w_sel;
  logic [WIDTH:0] w_opa;
  logic [WIDTH:0] w_opb;
  logic           w_cin;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_res;
  logic           r_valid;
  logic [WIDTH:0] r_y;

  assign w_sel = {s1, s0};

  // Route operands into the single adder; subtract is ~b with carry-in 1.
  always_comb begin
    w_opa = {1'b0, a1};
    w_opb = {1'b0, b};
    w_cin = 1'b0;
    unique case (w_sel)
      2'b00: begin
        w_opa = {1'b0, a1};
        w_opb = {1'b0, b};
      end
      2'b01: begin
        w_opa = {1'b0, a2};
        w_opb = {1'b0, b};
      end
      2'b10: begin
        w_opa = {1'b0, a1};
        w_opb = ~{1'b0, b};
        w_cin = 1'b1;
      end
      2'b11: begin
        w_opa = {1'b0, a1};
        w_opb = {1'b0, a2};
      end
      default: begin
        w_opa = {1'b0, a1};
        w_opb = {1'b0, b};
      end
    endcase
  end

  assign w_sum = w_opa + w_opb + {{WIDTH{1'b0}}, w_cin};

  // Top bit of a subtract is the borrow, set exactly when a1 < b.
`ifdef RECONFIG_SAT_EN
  assign w_res = (w_sel == 2'b10 && w_sum[WIDTH]) ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  // Result register: load on in_valid, hold otherwise; valid is a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y <= w_res;
      end
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;

endmodule

// File: tb/tb_reconfig_multi_topo_b.sv
// Scoreboard bench for reconfig_multi_topo_b.
// Directed spec cases followed by random traffic with random resets.
module tb_reconfig_multi_topo_b;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a1;
  logic [W-1:0] a2;
  logic [W-1:0] b;
  logic         s0;
  logic         s1;
  logic         out_valid;
  logic [W:0]   y;

  typedef struct {
    bit      v;
    int      y;
    string   tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_y      = 0;

  reconfig_multi_topo_b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a1        (a1),
    .a2        (a2),
    .b         (b),
    .s0        (s0),
    .s1        (s1),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  function automatic int model(int sel, int x1, int x2, int xb);
    int r;
    case (sel)
      0: r = x1 + xb;
      1: r = x2 + xb;
      2: begin
`ifdef RECONFIG_SAT_EN
        r = (x1 < xb) ? 0 : x1 - xb;
`else
        r = (x1 - xb + 512) % 512;
`endif
      end
      default: r = x1 + x2;
    endcase
    return r;
  endfunction

  // One clock: drive after the previous edge, predict the edge's effect.
  task automatic step(input bit rn, input bit v, input int sel,
                      input int x1, input int x2, input int xb,
                      input string tag);
    exp_t e;
    #1;
    rst_n    = rn;
    in_valid = v;
    {s1, s0} = sel[1:0];
    a1       = x1[W-1:0];
    a2       = x2[W-1:0];
    b        = xb[W-1:0];
    @(posedge clk);
    if (!rn) begin
      m_y = 0;
      e.v = 1'b0;
    end else if (v) begin
      m_y = model(sel, x1, x2, xb);
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.y   = m_y;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== e.v) begin
        failures++;
        $display("FAIL %s out_valid got=%0b want=%0b", e.tag, out_valid, e.v);
      end
      checks++;
      if (y !== e.y[W:0]) begin
        failures++;
        $display("FAIL %s y got=%0d want=%0d", e.tag, y, e.y);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a1 = '0; a2 = '0; b = '0; s0 = 1'b0; s1 = 1'b0;
    @(posedge clk);

    step(0, 1, 0, 5, 6, 7, "reset1");
    step(0, 1, 3, 9, 9, 9, "reset2");
    step(1, 0, 0, 1, 2, 3, "idle_after_reset");
    step(1, 1, 0, 3, 4, 5, "first_result");

    step(1, 1, 0, 240, 1, 63, "topo00");
    step(1, 1, 1, 240, 1, 63, "topo01");
    step(1, 1, 2, 240, 1, 63, "topo10");
    step(1, 1, 3, 240, 1, 63, "topo11");

    step(1, 1, 0, 255, 0, 255, "carry00");
    step(1, 1, 3, 255, 255, 0, "carry11");
    step(1, 1, 2, 10, 0, 20, "sub_below0");
    step(1, 1, 2, 77, 0, 77, "sub_equal");
    step(1, 1, 2, 0, 0, 255, "sub_min");

    step(1, 1, 1, 100, 50, 25, "pre_hold");
    step(1, 0, 0, 11, 22, 33, "hold1");
    step(1, 0, 3, 200, 201, 202, "hold2");

    step(1, 1, 0, 1, 1, 1, "pre_midreset");
    step(0, 1, 3, 50, 60, 70, "midreset");
    step(1, 1, 3, 50, 60, 70, "resume");
    step(1, 1, 2, 70, 60, 50, "resume2");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 3), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255), "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
